// File: rtl/sd_sector_scheduler.sv
// Ping-pong sector buffer and SD write sequencer for streaming capture.
// Define SD_SCHED_WRAP_EN to turn the recording region into a circular log.
module sd_sector_scheduler #(
    parameter logic [31:0] START_SECTOR     = 32'd2048,
    parameter logic [31:0] NUM_SECTORS      = 32'd65536,
    parameter int          WORDS_PER_SECTOR = 256
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    input  logic        init_end,
    input  logic        wr_busy,
    input  logic        wr_req,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [15:0] wr_data,
    output logic [31:0] sector_count,
    output logic        overflow,
    output logic        region_full
);

    localparam int PTR_W = $clog2(WORDS_PER_SECTOR);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WORDS_PER_SECTOR - 1);
    localparam logic [31:0] LAST_SECTOR = START_SECTOR + NUM_SECTORS - 32'd1;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WAIT_BUSY,
        XFER,
        FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      mem_q [2][WORDS_PER_SECTOR];
    logic [1:0]       full_q, full_d;
    logic             fill_sel_q, fill_sel_d;
    logic [PTR_W-1:0] fill_ptr_q, fill_ptr_d;
    logic             drain_sel_q, drain_sel_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rd_nxt;
    logic [31:0]      wr_addr_q, wr_addr_d;
    logic [15:0]      wr_data_q, wr_data_d;
    logic [31:0]      sector_count_q, sector_count_d;
    logic             overflow_q, overflow_d;
    logic             region_full_q, region_full_d;
    logic             accept;
    logic             fill_done;
    logic             clear_drain;

    assign in_ready     = !full_q[fill_sel_q] && !region_full_q;
    assign accept       = in_valid && in_ready;
    assign fill_done    = accept && (fill_ptr_q == PTR_LAST);
    assign rd_nxt       = rd_ptr_q + 1'b1;
    assign wr_en        = (state_q == CMD);
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign sector_count = sector_count_q;
    assign overflow     = overflow_q;
    assign region_full  = region_full_q;

    // Fill side; a completing fill and a drain release never hit the same buffer.
    always_comb begin
        full_d     = full_q;
        fill_sel_d = fill_sel_q;
        fill_ptr_d = fill_ptr_q;
        overflow_d = overflow_q;
        if (accept) begin
            fill_ptr_d = fill_ptr_q + 1'b1;
        end
        if (fill_done) begin
            fill_ptr_d = '0;
            fill_sel_d = !fill_sel_q;
        end
        if (in_valid && !in_ready) begin
            overflow_d = 1'b1;
        end
        if (clear_drain) begin
            full_d[drain_sel_q] = 1'b0;
        end
        if (fill_done) begin
            full_d[fill_sel_q] = 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        drain_sel_d    = drain_sel_q;
        rd_ptr_d       = rd_ptr_q;
        wr_data_d      = wr_data_q;
        wr_addr_d      = wr_addr_q;
        sector_count_d = sector_count_q;
        region_full_d  = region_full_q;
        clear_drain    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (full_q[drain_sel_q] && init_end && !wr_busy && !region_full_q) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                rd_ptr_d  = '0;
                wr_data_d = mem_q[drain_sel_q][0];
                state_d   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (wr_busy) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                // Pointer saturates so surplus requests repeat the last word.
                if (wr_req && (rd_ptr_q != PTR_LAST)) begin
                    rd_ptr_d  = rd_nxt;
                    wr_data_d = mem_q[drain_sel_q][rd_nxt];
                end
                if (!wr_busy) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                clear_drain    = 1'b1;
                drain_sel_d    = !drain_sel_q;
                sector_count_d = sector_count_q + 32'd1;
`ifdef SD_SCHED_WRAP_EN
                wr_addr_d = (wr_addr_q == LAST_SECTOR) ? START_SECTOR
                                                       : wr_addr_q + 32'd1;
`else
                wr_addr_d = wr_addr_q + 32'd1;
                if (wr_addr_q == LAST_SECTOR) begin
                    region_full_d = 1'b1;
                end
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sector storage is not reset; the full flags decide what is valid.
    always_ff @(posedge sys_clk) begin
        if (accept) begin
            mem_q[fill_sel_q][fill_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q        <= IDLE;
            full_q         <= 2'b00;
            fill_sel_q     <= 1'b0;
            fill_ptr_q     <= '0;
            drain_sel_q    <= 1'b0;
            rd_ptr_q       <= '0;
            wr_addr_q      <= START_SECTOR;
            wr_data_q      <= 16'h0000;
            sector_count_q <= 32'd0;
            overflow_q     <= 1'b0;
            region_full_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            full_q         <= full_d;
            fill_sel_q     <= fill_sel_d;
            fill_ptr_q     <= fill_ptr_d;
            drain_sel_q    <= drain_sel_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            sector_count_q <= sector_count_d;
            overflow_q     <= overflow_d;
            region_full_q  <= region_full_d;
        end
    end

endmodule

// File: tb/tb_sd_sector_scheduler.sv
// Scoreboard bench for sd_sector_scheduler with a behavioural SD writer model.
// Recording region shrunk to 4 sectors so the end-of-region path is reachable.
module tb_sd_sector_scheduler;

    localparam logic [31:0] START = 32'd2048;
    localparam logic [31:0] NSEC  = 32'd4;
    localparam int          W     = 256;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        init_end;
    logic        wr_busy;
    logic        wr_req;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [15:0] wr_data;
    logic [31:0] sector_count;
    logic        overflow;
    logic        region_full;

    always #10 sys_clk = ~sys_clk;

    sd_sector_scheduler #(
        .START_SECTOR    (START),
        .NUM_SECTORS     (NSEC),
        .WORDS_PER_SECTOR(W)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .init_end    (init_end),
        .wr_busy     (wr_busy),
        .wr_req      (wr_req),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .sector_count(sector_count),
        .overflow    (overflow),
        .region_full (region_full)
    );

    // Scoreboard state
    logic [15:0] exp_words[$];
    string       chk_name[$];
    logic [31:0] chk_act[$];
    logic [31:0] chk_exp[$];
    logic [15:0] got_words[$];
    logic [31:0] got_addr[$];
    logic [15:0] got_extra[$];
    logic        got_bad[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_done = 0;
    int          base_done = 0;

    // Writer model controls and state
    int          n_wr_en = 0;
    int          base_wen = 0;
    logic        w_kill;
    int          w_hold_cfg;
    int          w_gap_max;
    int          ws = 0;
    int          w_dly, w_gap, w_idx = 0, w_cyc, w_hold;
    logic [31:0] cur_addr;
    logic        bad;
    logic [15:0] extra;
    logic [15:0] w_buf[W];
    bit          saw_not_ready;

    always @(negedge sys_clk) begin
        if (!sys_rst_n || w_kill) begin
            ws = 0;
            w_idx = 0;
            wr_busy = 1'b0;
            wr_req = 1'b0;
        end else begin
            case (ws)
                0: if (wr_en) begin
                    n_wr_en++;
                    cur_addr = wr_addr;
                    bad = 1'b0;
                    w_idx = 0;
                    w_cyc = 0;
                    w_gap = 0;
                    w_dly = $urandom_range(0, 3);
                    w_hold = (w_hold_cfg != 0) ? w_hold_cfg : $urandom_range(260, 340);
                    ws = 1;
                end
                1: if (w_dly == 0) begin
                    wr_busy = 1'b1;
                    ws = 2;
                end else begin
                    w_dly--;
                end
                2: ws = 3;
                3: begin
                    w_cyc++;
                    if (wr_addr != cur_addr) bad = 1'b1;
                    if (w_gap > 0) begin
                        wr_req = 1'b0;
                        w_gap--;
                    end else if (w_idx < W) begin
                        w_buf[w_idx] = wr_data;
                        w_idx++;
                        wr_req = 1'b1;
                        w_gap = $urandom_range(0, w_gap_max);
                    end else if (w_idx == W) begin
                        wr_req = 1'b1;
                        w_idx++;
                    end else begin
                        extra = wr_data;
                        wr_req = 1'b0;
                        ws = 4;
                    end
                end
                4: begin
                    w_cyc++;
                    if (wr_addr != cur_addr) bad = 1'b1;
                    if (w_cyc >= w_hold) begin
                        wr_busy = 1'b0;
                        ws = 5;
                    end
                end
                default: begin
                    for (int i = 0; i < W; i++) got_words.push_back(w_buf[i]);
                    got_addr.push_back(cur_addr);
                    got_extra.push_back(extra);
                    got_bad.push_back(bad);
                    w_idx = 0;
                    ws = 0;
                end
            endcase
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: the only process that compares.
    int          mk, mism;
    logic [31:0] exp_a;
    logic [15:0] mw, me, last_e;
    initial begin
        forever begin
            @(posedge sys_clk);
            while (chk_name.size() > 0) begin
                check(chk_name.pop_front(), chk_act.pop_front(), chk_exp.pop_front());
            end
            while (got_addr.size() > 0) begin
                mk = n_done - base_done;
`ifdef SD_SCHED_WRAP_EN
                exp_a = START + 32'(mk % int'(NSEC));
`else
                exp_a = START + 32'(mk);
`endif
                check("sector_addr", got_addr.pop_front(), exp_a);
                check("addr_stable", 32'(got_bad.pop_front()), 32'd0);
                mism = 0;
                last_e = 16'h0;
                for (int i = 0; i < W; i++) begin
                    mw = got_words.pop_front();
                    if (exp_words.size() == 0) begin
                        mism++;
                    end else begin
                        me = exp_words.pop_front();
                        last_e = me;
                        if (mw != me) mism++;
                    end
                end
                check("sector_data_mismatches", 32'(mism), 32'd0);
                check("repeat_last_word", 32'(got_extra.pop_front()), 32'(last_e));
                n_done++;
            end
        end
    end

    task automatic expect_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_name.push_back(nm);
        chk_act.push_back(act);
        chk_exp.push_back(exp);
    endtask

    task automatic send(input int n, input int max_gap, input bit seq,
                        input int budget, output int sent);
        int t;
        t = 0;
        sent = 0;
        while (sent < n && t < budget) begin
            @(negedge sys_clk);
            t++;
            in_valid = 1'b0;
            if (max_gap > 0 && $urandom_range(0, max_gap) == 0) continue;
            if (in_ready) begin
                in_data = seq ? 16'(sent) : 16'($urandom);
                in_valid = 1'b1;
                exp_words.push_back(in_data);
                sent++;
            end else begin
                saw_not_ready = 1'b1;
            end
        end
        @(negedge sys_clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int t;
        t = 0;
        while ((n_done - base_done) < target && t < budget) begin
            @(negedge sys_clk);
            t++;
        end
        expect_eq("sectors_done", 32'(n_done - base_done), 32'(target));
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic release_reset();
        @(negedge sys_clk);
        exp_words.delete();
        sys_rst_n = 1'b1;
        w_kill = 1'b0;
        base_done = n_done;
        base_wen = n_wr_en;
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        w_kill = 1'b1;
        in_valid = 1'b0;
        @(negedge sys_clk);
        release_reset();
    endtask

    initial begin
        #1200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int sent;
    bit seen;
    int t;
    initial begin
        sys_rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 16'h0;
        init_end = 1'b0;
        w_kill = 1'b0;
        w_hold_cfg = 300;
        w_gap_max = 0;
        repeat (3) @(negedge sys_clk);
        release_reset();
        @(negedge sys_clk);
        expect_eq("rst_wr_en", 32'(wr_en), 32'd0);
        expect_eq("rst_wr_addr", wr_addr, START);
        expect_eq("rst_wr_data", 32'(wr_data), 32'd0);
        expect_eq("rst_sector_count", sector_count, 32'd0);
        expect_eq("rst_overflow", 32'(overflow), 32'd0);
        expect_eq("rst_region_full", 32'(region_full), 32'd0);
        expect_eq("rst_in_ready", 32'(in_ready), 32'd1);

        // One sector of ramp data
        init_end = 1'b1;
        send(W, 0, 1'b1, 1000, sent);
        wait_done(1, 3000);
        expect_eq("p1_sector_count", sector_count, 32'd1);
        expect_eq("p1_wr_en_count", 32'(n_wr_en - base_wen), 32'd1);

        // Back-pressure with a slow writer
        do_reset();
        w_hold_cfg = 600;
        saw_not_ready = 1'b0;
        send(3 * W, 0, 1'b0, 5000, sent);
        expect_eq("p2_sent", 32'(sent), 32'(3 * W));
        expect_eq("p2_saw_backpressure", 32'(saw_not_ready), 32'd1);
        wait_done(3, 5000);
        expect_eq("p2_overflow", 32'(overflow), 32'd0);
        expect_eq("p2_sector_count", sector_count, 32'd3);

        // Card not initialised, then overflow, then release
        do_reset();
        init_end = 1'b0;
        w_hold_cfg = 0;
        w_gap_max = 1;
        send(2 * W, 1, 1'b0, 3000, sent);
        expect_eq("p3_sent", 32'(sent), 32'(2 * W));
        repeat (20) @(negedge sys_clk);
        expect_eq("p3_no_wr_en", 32'(n_wr_en - base_wen), 32'd0);
        expect_eq("p3_in_ready_low", 32'(in_ready), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            in_data = 16'hBAD0 + 16'(i);
            in_valid = 1'b1;
        end
        @(negedge sys_clk);
        in_valid = 1'b0;
        expect_eq("p3_overflow_set", 32'(overflow), 32'd1);
        init_end = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2 && !seen; i++) begin
            @(negedge sys_clk);
            if (wr_en) seen = 1'b1;
        end
        expect_eq("p3_wr_en_after_init", 32'(seen), 32'd1);
        wait_done(2, 5000);
        expect_eq("p3_overflow_sticky", 32'(overflow), 32'd1);
        expect_eq("p3_sector_count", sector_count, 32'd2);

        // Randomised traffic on both sides
        do_reset();
        w_gap_max = 2;
        send(3 * W, 3, 1'b0, 8000, sent);
        expect_eq("p4_sent", 32'(sent), 32'(3 * W));
        wait_done(3, 8000);
        expect_eq("p4_sector_count", sector_count, 32'd3);

        // Reset in the middle of a transfer
        w_gap_max = 0;
        w_hold_cfg = 400;
        send(W, 0, 1'b0, 2000, sent);
        t = 0;
        while (w_idx < 100 && t < 2000) begin
            @(negedge sys_clk);
            t++;
        end
        expect_eq("p5_reached_100_req", 32'(w_idx >= 100), 32'd1);
        sys_rst_n = 1'b0;
        w_kill = 1'b1;
        @(negedge sys_clk);
        expect_eq("p5_wr_en", 32'(wr_en), 32'd0);
        expect_eq("p5_sector_count", sector_count, 32'd0);
        expect_eq("p5_wr_addr", wr_addr, START);
        expect_eq("p5_in_ready", 32'(in_ready), 32'd1);
        release_reset();

        // End of the recording region
        w_hold_cfg = 400;
        send(5 * W, 0, 1'b0, 6000, sent);
        expect_eq("p6_sent", 32'(sent), 32'(5 * W));
`ifdef SD_SCHED_WRAP_EN
        wait_done(5, 6000);
        expect_eq("p6_region_full", 32'(region_full), 32'd0);
        expect_eq("p6_wr_en_count", 32'(n_wr_en - base_wen), 32'd5);
        expect_eq("p6_sector_count", sector_count, 32'd5);
`else
        wait_done(4, 6000);
        repeat (300) @(negedge sys_clk);
        expect_eq("p6_region_full", 32'(region_full), 32'd1);
        expect_eq("p6_wr_en_count", 32'(n_wr_en - base_wen), 32'd4);
        expect_eq("p6_in_ready", 32'(in_ready), 32'd0);
        expect_eq("p6_sector_count", sector_count, 32'd4);
`endif

        repeat (5) @(negedge sys_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
